// File: rtl/ret_stack_ctrl.sv
// ret_stack_ctrl: hardware return-address stack (LIFO) for CALL/RET decode.
// A DEPTH x AW register array is addressed by a modulo-DEPTH stack pointer.
// The pointer names the next free slot, so the top entry lives at sp-1.
// Outputs depend only on registered state.
// Optional macro RET_STACK_WRAP_EN: a push-only while full overwrites the
// oldest entry as a circular buffer. Without it, that push is dropped and
// sets the sticky overflow flag.
module ret_stack_ctrl #(
  parameter int AW    = 19,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [AW-1:0]          push_addr,
  input  logic                   clr_err,
  output logic [AW-1:0]          top_addr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] sp;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          unf;
  logic [PW-1:0] top_idx;

  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] sp_nx;
  logic [CW-1:0] cnt_nx;
  logic          ovf_set;
  logic          unf_set;

  assign top_idx   = sp - PW'(1);
  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_FULL);
  // Stale array contents are masked so an empty stack always reads 0.
  assign top_addr  = empty ? '0 : mem[top_idx];
  assign count     = cnt;
  assign overflow  = ovf;
  assign underflow = unf;

  // Decode push/pop against the current fill level into next-state controls.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sp;
    sp_nx   = sp;
    cnt_nx  = cnt;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push && pop) begin
      if (empty) begin
        // Nothing to pop: the push still lands, the pop is flagged.
        wr_en   = 1'b1;
        wr_idx  = sp;
        sp_nx   = sp + PW'(1);
        cnt_nx  = CW'(1);
        unf_set = 1'b1;
      end else begin
        // RET followed by CALL: replace the top entry in place.
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
    end else if (push) begin
      if (!full) begin
        wr_en  = 1'b1;
        wr_idx = sp;
        sp_nx  = sp + PW'(1);
        cnt_nx = cnt + CW'(1);
      end else begin
`ifdef RET_STACK_WRAP_EN
        // When full, sp wraps onto the oldest entry, which gets overwritten.
        wr_en  = 1'b1;
        wr_idx = sp;
        sp_nx  = sp + PW'(1);
`else
        ovf_set = 1'b1;
`endif
      end
    end else if (pop) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        sp_nx  = top_idx;
        cnt_nx = cnt - CW'(1);
      end
    end
  end

  // Array write; contents are never reset since empty masks them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_addr;
    end
  end

  // Pointer, count and sticky error flags; a new error beats clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp  <= sp_nx;
      cnt <= cnt_nx;
      ovf <= ovf_set | (ovf & ~clr_err);
      unf <= unf_set | (unf & ~clr_err);
    end
  end

endmodule

// File: tb/tb_ret_stack_ctrl.sv
// Testbench for ret_stack_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_ret_stack_ctrl;

  localparam int AW    = 19;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_addr;
  logic          clr_err;
  logic [AW-1:0] top_addr;
  logic [4:0]    count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  ret_stack_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .push_addr(push_addr), .clr_err(clr_err), .top_addr(top_addr),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic          pop;
    logic          clr;
    logic [AW-1:0] addr;
    int            cnt;
    logic [AW-1:0] top;
    logic          e;
    logic          f;
    logic          o;
    logic          u;
  } vec_t;

  vec_t vecs[19];

  // Reference model: a queue whose back is the top of stack.
  logic [AW-1:0] mq[$];
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic p, input logic q, input logic c,
                               input logic [AW-1:0] a, input int n,
                               input logic [AW-1:0] t, input logic e,
                               input logic f, input logic o, input logic u);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.addr = a; v.cnt = n;
    v.top = t; v.e = e; v.f = f; v.o = o; v.u = u;
    return v;
  endfunction

  function automatic void model_step(input logic p, input logic q, input logic c,
                                     input logic [AW-1:0] a);
    logic os, us;
    os = 1'b0;
    us = 1'b0;
    if (p && q) begin
      if (mq.size() == 0) begin
        mq.push_back(a);
        us = 1'b1;
      end else begin
        mq[mq.size()-1] = a;
      end
    end else if (p) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(a);
      end else begin
`ifdef RET_STACK_WRAP_EN
        void'(mq.pop_front());
        mq.push_back(a);
`else
        os = 1'b1;
`endif
      end
    end else if (q) begin
      if (mq.size() == 0) us = 1'b1;
      else void'(mq.pop_back());
    end
    m_ovf = os | (m_ovf & ~c);
    m_unf = us | (m_unf & ~c);
  endfunction

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_addr = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Apply one cycle of inputs; returns 1 ns after the active edge.
  task automatic step(input logic p, input logic q, input logic c, input logic [AW-1:0] a);
    push = p; pop = q; clr_err = c; push_addr = a;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_state(input string tag, input int n, input logic [AW-1:0] t,
                             input logic e, input logic f, input logic o, input logic u);
    chk({tag, " count"}, 32'(count), 32'(n));
    chk({tag, " top_addr"}, 32'(top_addr), 32'(t));
    chk({tag, " empty"}, 32'(empty), 32'(e));
    chk({tag, " full"}, 32'(full), 32'(f));
    chk({tag, " overflow"}, 32'(overflow), 32'(o));
    chk({tag, " underflow"}, 32'(underflow), 32'(u));
  endtask

  task automatic check_model(input string tag);
    logic [AW-1:0] t;
    t = (mq.size() == 0) ? '0 : mq[mq.size()-1];
    check_state(tag, mq.size(), t, mq.size() == 0, mq.size() == DEPTH, m_ovf, m_unf);
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_addr = '0;

    //          push pop clr addr      cnt top       e  f  o  u
    vecs[0]  = mkv(1, 0, 0, 19'h00100, 1, 19'h00100, 0, 0, 0, 0);
    vecs[1]  = mkv(1, 0, 0, 19'h00200, 2, 19'h00200, 0, 0, 0, 0);
    vecs[2]  = mkv(1, 0, 0, 19'h00300, 3, 19'h00300, 0, 0, 0, 0);
    vecs[3]  = mkv(0, 1, 0, 19'h00000, 2, 19'h00200, 0, 0, 0, 0);
    vecs[4]  = mkv(0, 1, 0, 19'h00000, 1, 19'h00100, 0, 0, 0, 0);
    vecs[5]  = mkv(0, 1, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 0);
    vecs[6]  = mkv(0, 1, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 1);
    vecs[7]  = mkv(0, 0, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 1);
    vecs[8]  = mkv(0, 0, 1, 19'h00000, 0, 19'h00000, 1, 0, 0, 0);
    vecs[9]  = mkv(0, 1, 1, 19'h00000, 0, 19'h00000, 1, 0, 0, 1);
    vecs[10] = mkv(0, 0, 1, 19'h00000, 0, 19'h00000, 1, 0, 0, 0);
    vecs[11] = mkv(1, 0, 0, 19'h00555, 1, 19'h00555, 0, 0, 0, 0);
    vecs[12] = mkv(1, 0, 0, 19'h00AAA, 2, 19'h00AAA, 0, 0, 0, 0);
    vecs[13] = mkv(1, 1, 0, 19'h00BBB, 2, 19'h00BBB, 0, 0, 0, 0);
    vecs[14] = mkv(0, 1, 0, 19'h00000, 1, 19'h00555, 0, 0, 0, 0);
    vecs[15] = mkv(0, 1, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 0);
    vecs[16] = mkv(1, 1, 0, 19'h00CCC, 1, 19'h00CCC, 0, 0, 0, 1);
    vecs[17] = mkv(0, 0, 1, 19'h00000, 1, 19'h00CCC, 0, 0, 0, 0);
    vecs[18] = mkv(0, 1, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 0);

    // Reset state while rst_n is held low.
    #2;
    check_state("reset", 0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_state("after_reset", 0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Directed vector table.
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].addr);
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].top,
                  vecs[i].e, vecs[i].f, vecs[i].o, vecs[i].u);
    end

    // Fill to DEPTH, then push once more while full.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 1'b0, AW'(i));
    check_state("filled", DEPTH, 19'h00010, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 19'h7FFFF);
`ifdef RET_STACK_WRAP_EN
    check_state("wrap_push", DEPTH, 19'h7FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("wrap_pop0 top_addr", 32'(top_addr), 32'h10);
    for (int i = 2; i <= DEPTH; i++) begin
      chk($sformatf("wrap_pop%0d top_addr", i - 1), 32'(top_addr), 32'(18 - i));
      step(1'b0, 1'b1, 1'b0, '0);
    end
    check_state("wrap_drained", 0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    check_state("ovf_push", DEPTH, 19'h00010, 1'b0, 1'b1, 1'b1, 1'b0);
    // Replace-top while full never overflows; overflow stays sticky.
    step(1'b1, 1'b1, 1'b0, 19'h00077);
    check_state("full_swap", DEPTH, 19'h00077, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_state("ovf_pop", DEPTH - 1, 19'h0000F, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = DEPTH - 1; i >= 1; i--) begin
      chk($sformatf("drain%0d top_addr", i), 32'(top_addr), 32'(i));
      step(1'b0, 1'b1, 1'b0, '0);
    end
    check_state("drained", 0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, '0);
    check_state("ovf_clr", 0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset between edges after 5 pushes.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, AW'(32'h100 * (i + 1)));
    check_state("five", 5, 19'h00500, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 19'h01234);
    check_state("post_rst", 1, 19'h01234, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic in push-heavy, pop-heavy and balanced phases.
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      int pp, pq;
      pp = (ph == 0) ? 75 : (ph == 1) ? 20 : 50;
      pq = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
      for (int n = 0; n < 600; n++) begin
        logic p, q, c;
        logic [AW-1:0] a;
        p = ($urandom_range(0, 99) < pp);
        q = ($urandom_range(0, 99) < pq);
        c = ($urandom_range(0, 99) < 8);
        a = AW'($urandom);
        step(p, q, c, a);
        model_step(p, q, c, a);
        check_model($sformatf("rand%0d_%0d", ph, n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
